// File: rtl/uart_rx_if.sv
// Bundles the UART receiver's serial input, frame configuration and received-data outputs.
// The master side drives the line and configuration; the slave side is the receiver.
interface uart_rx_if #(
  parameter int DATA_LEN   = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_LEN-1:0]   P_DATA;
  logic                  Data_Valid;
  logic                  Par_Err;
  logic                  Stp_Err;

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, Data_Valid, Par_Err, Stp_Err
  );

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, Data_Valid, Par_Err, Stp_Err
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 3-sample majority per bit, start-glitch rejection, optional parity, stop check.
// Optional feature macro UART_RX_SYNC_EN inserts a 2-FF synchronizer on RX_IN (adds 2 clocks of latency).
module uart_rx #(
  parameter int DATA_LEN   = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  localparam int BW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic rx;

`ifdef UART_RX_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.RX_IN;
      sync2_q <= sync1_q;
    end
  end

  assign rx = sync2_q;
`else
  assign rx = bus.RX_IN;
`endif

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;
  logic [DATA_LEN-1:0]   shift_q, shift_d;
  logic                  par_int_q, par_int_d;
  logic                  done_q, done_d;
  logic                  stop_q, stop_d;
  logic [DATA_LEN-1:0]   p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;

  logic [PRESCALE_W-1:0] half, pm1, samp0, samp2;
  logic                  at_samp0, at_samp1, at_dec, at_end;
  logic                  bit_val, exp_par;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      shift_q    <= '0;
      par_int_q  <= 1'b0;
      done_q     <= 1'b0;
      stop_q     <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      shift_q    <= shift_d;
      par_int_q  <= par_int_d;
      done_q     <= done_d;
      stop_q     <= stop_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  // Sample points are derived from the prescale latched at frame start.
  always_comb begin
    half     = prescale_q >> 1;
    pm1      = prescale_q - PRESCALE_W'(1);
    samp0    = half - PRESCALE_W'(1);
    samp2    = half + PRESCALE_W'(1);
    at_samp0 = (edge_q == samp0);
    at_samp1 = (edge_q == half);
    at_dec   = (edge_q == samp2);
    at_end   = (edge_q == pm1);
    bit_val  = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
    exp_par  = (^shift_q) ^ ~par_typ_q;
  end

  always_comb begin
    state_d    = state_q;
    edge_d     = at_end ? '0 : edge_q + PRESCALE_W'(1);
    bit_d      = bit_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    s0_d       = at_samp0 ? rx : s0_q;
    s1_d       = at_samp1 ? rx : s1_q;
    shift_d    = shift_q;
    par_int_d  = par_int_q;
    done_d     = 1'b0;
    stop_d     = stop_q;

    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (!rx) begin
          // The cycle that sees the falling edge is edge 0 of the start bit.
          state_d    = START;
          edge_d     = PRESCALE_W'(1);
          prescale_d = bus.PRESCALE;
          par_en_d   = bus.PAR_EN;
          par_typ_d  = bus.PAR_TYP;
          par_int_d  = 1'b0;
        end
      end
      START: begin
        if (at_dec && bit_val) begin
          state_d = IDLE;
          edge_d  = '0;
        end else if (at_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_dec) begin
          shift_d[bit_q] = bit_val;
        end
        if (at_end) begin
          if (bit_q == BW'(DATA_LEN - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (at_dec) begin
          par_int_d = (bit_val != exp_par);
        end
        if (at_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Leave half a bit early so a back-to-back start bit is caught; the
        // end-of-bit exit only matters for unsupported prescale values.
        if (at_dec || at_end) begin
          state_d = IDLE;
          edge_d  = '0;
        end
        if (at_dec) begin
          done_d = 1'b1;
          stop_d = bit_val;
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
      end
    endcase
  end

  always_comb begin
    dv_d     = done_q & stop_q & ~par_int_q;
    perr_d   = done_q & par_int_q;
    serr_d   = done_q & ~stop_q;
    p_data_d = dv_d ? shift_q : p_data_q;
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.Data_Valid = dv_q;
  assign bus.Par_Err    = perr_q;
  assign bus.Stp_Err    = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frame bench for uart_rx; a frame-level model predicts every pulse,
// its exact clock and the held P_DATA value.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_LEN(8), .PRESCALE_W(6)) bus ();

  uart_rx #(.DATA_LEN(8), .PRESCALE_W(6)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed pulses
  int         mon_dv_cyc[$];
  logic [7:0] mon_dv_data[$];
  int         mon_par_cyc[$];
  int         mon_stp_cyc[$];

  always @(negedge clk) begin
    if (bus.Data_Valid === 1'b1) begin
      mon_dv_cyc.push_back(cyc);
      mon_dv_data.push_back(bus.P_DATA);
    end
    if (bus.Par_Err === 1'b1) mon_par_cyc.push_back(cyc);
    if (bus.Stp_Err === 1'b1) mon_stp_cyc.push_back(cyc);
  end

  // Expected pulses
  int         exp_dv_cyc[$];
  logic [7:0] exp_dv_data[$];
  int         exp_par_cyc[$];
  int         exp_stp_cyc[$];
  logic [7:0] exp_pdata = 8'h00;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting now (caller is 1 time unit after a rising edge)
  // and records the outcome the protocol rules predict.
  task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                            input bit bad_par, input bit stop);
    logic bits[$];
    logic par;
    int   c, n, t;
    bit   perr, serr;
    c   = cyc;
    par = ptyp ? (^d) : ~(^d);
    if (bad_par) par = ~par;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(par);
    bits.push_back(stop);

    bus.PRESCALE = 6'(p);
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    foreach (bits[i]) begin
      bus.RX_IN = bits[i];
      idle(p);
    end
    bus.RX_IN = 1'b1;

    // Line edge at c seen at c+1; stop bit n decided at edge P/2+1; output one clock later.
    n    = bits.size() - 1;
    t    = c + 1 + SYNC + n * p + p / 2 + 2;
    perr = pen && bad_par;
    serr = !stop;
    if (perr) exp_par_cyc.push_back(t);
    if (serr) exp_stp_cyc.push_back(t);
    if (!perr && !serr) begin
      exp_dv_cyc.push_back(t);
      exp_dv_data.push_back(d);
      exp_pdata = d;
    end
  endtask

  task automatic verify(input string tag);
    chk({tag, ".dv_count"}, mon_dv_cyc.size(), exp_dv_cyc.size());
    chk({tag, ".par_count"}, mon_par_cyc.size(), exp_par_cyc.size());
    chk({tag, ".stp_count"}, mon_stp_cyc.size(), exp_stp_cyc.size());
    for (int i = 0; i < mon_dv_cyc.size() && i < exp_dv_cyc.size(); i++) begin
      chk({tag, ".dv_cycle"}, mon_dv_cyc[i], exp_dv_cyc[i]);
      chk({tag, ".dv_data"}, {24'h0, mon_dv_data[i]}, {24'h0, exp_dv_data[i]});
    end
    for (int i = 0; i < mon_par_cyc.size() && i < exp_par_cyc.size(); i++)
      chk({tag, ".par_cycle"}, mon_par_cyc[i], exp_par_cyc[i]);
    for (int i = 0; i < mon_stp_cyc.size() && i < exp_stp_cyc.size(); i++)
      chk({tag, ".stp_cycle"}, mon_stp_cyc[i], exp_stp_cyc[i]);
    chk({tag, ".p_data_held"}, {24'h0, bus.P_DATA}, {24'h0, exp_pdata});
    $display("frame %s: dv=%0d par_err=%0d stp_err=%0d p_data=%02h", tag,
             mon_dv_cyc.size(), mon_par_cyc.size(), mon_stp_cyc.size(), bus.P_DATA);
    mon_dv_cyc.delete();
    mon_dv_data.delete();
    mon_par_cyc.delete();
    mon_stp_cyc.delete();
    exp_dv_cyc.delete();
    exp_dv_data.delete();
    exp_par_cyc.delete();
    exp_stp_cyc.delete();
  endtask

  initial begin
    int         p;
    bit         pen, ptyp, badp, stp;
    logic [7:0] d;

    bus.RX_IN    = 1'b1;
    bus.PRESCALE = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;

    // Reset state
    idle(3);
    chk("rst.p_data", {24'h0, bus.P_DATA}, 32'h0);
    chk("rst.flags", {29'h0, bus.Data_Valid, bus.Par_Err, bus.Stp_Err}, 32'h0);
    rst_n = 1'b1;
    idle(4);

    // 1: plain frame
    send_frame(8'hF8, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(20);
    verify("t1_F8");

    // 2: odd parity good, then bad
    send_frame(8'h6F, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(20);
    verify("t2_par_ok");
    send_frame(8'h6F, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(20);
    verify("t2_par_bad");

    // 3: stop bit error
    send_frame(8'h5D, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(40);
    verify("t3_stop_err");

    // 4: start glitch, then a good frame
    bus.PRESCALE = 6'd16;
    bus.PAR_EN   = 1'b0;
    bus.RX_IN    = 1'b0;
    idle(3);
    bus.RX_IN = 1'b1;
    idle(40);
    verify("t4_glitch");
    send_frame(8'h78, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(40);
    verify("t4_78");

    // 5: back-to-back frames at prescale 32
    send_frame(8'h6F, 32, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h78, 32, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(64);
    if (mon_dv_cyc.size() == 2)
      chk("t5.spacing", mon_dv_cyc[1] - mon_dv_cyc[0], 11 * 32);
    verify("t5_b2b");

    // 6: reset during data bit 4 of 0xA5
    d = 8'hA5;
    bus.PRESCALE = 6'd16;
    bus.PAR_EN   = 1'b0;
    bus.RX_IN    = 1'b0;
    idle(16);
    for (int i = 0; i < 4; i++) begin
      bus.RX_IN = d[i];
      idle(16);
    end
    bus.RX_IN = d[4];
    idle(8);
    rst_n = 1'b0;
    #1;
    chk("t6.rst_p_data", {24'h0, bus.P_DATA}, 32'h0);
    chk("t6.rst_flags", {29'h0, bus.Data_Valid, bus.Par_Err, bus.Stp_Err}, 32'h0);
    bus.RX_IN = 1'b1;
    exp_pdata = 8'h00;
    idle(5);
    rst_n = 1'b1;
    idle(40);
    verify("t6_abort");
    send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(40);
    verify("t6_A5");

    // Randomized frames over the supported prescale range
    for (int k = 0; k < 16; k++) begin
      p    = 8 + 2 * $urandom_range(0, 12);
      d    = 8'($urandom());
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      badp = pen && ($urandom_range(0, 3) == 0);
      stp  = ($urandom_range(0, 4) != 0);
      send_frame(d, p, pen, ptyp, badp, stp);
      idle(2 * p + 8);
      verify($sformatf("rand%0d_p%0d_%02h", k, p, d));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
